// File: rtl/note_envelope.sv
//------------------------------------------------------------------------------
// Module   : note_envelope
// Purpose  : Per-voice ADSR amplitude envelope applied to a raw sample stream.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module note_envelope #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int AMP_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           note_on,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_in_ready,
    input  logic        [AMP_WIDTH-1:0]    attack_step,
    input  logic        [AMP_WIDTH-1:0]    decay_step,
    input  logic        [AMP_WIDTH-1:0]    sustain_level,
    input  logic        [AMP_WIDTH-1:0]    release_step,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_out_ready,
    output logic        [AMP_WIDTH-1:0]    amp,
    output logic                           active
);

    localparam int PROD_WIDTH = SAMPLE_WIDTH + AMP_WIDTH + 1;
    localparam logic [AMP_WIDTH-1:0] c_amp_full = {AMP_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                          r_state;
    state_t                          w_next_state;
    logic        [AMP_WIDTH-1:0]     r_amp;
    logic        [AMP_WIDTH-1:0]     w_next_amp;
    logic                            r_note_prev;
    logic signed [SAMPLE_WIDTH-1:0]  r_sample_out;
    logic                            r_sample_out_ready;

    logic                            w_rise;
    logic                            w_fall;
    logic        [AMP_WIDTH:0]       w_sum_attack;
    logic        [AMP_WIDTH:0]       w_diff_decay;
    logic        [AMP_WIDTH:0]       w_diff_release;
    logic signed [PROD_WIDTH-1:0]    w_product;
    logic                            w_unused_bits;

    assign w_rise = note_on & ~r_note_prev;
    assign w_fall = ~note_on & r_note_prev;

    // Extra top bit catches both saturation overflow and subtraction underflow
    assign w_sum_attack   = {1'b0, r_amp} + {1'b0, attack_step};
    assign w_diff_decay   = {1'b0, r_amp} - {1'b0, decay_step};
    assign w_diff_release = {1'b0, r_amp} - {1'b0, release_step};

    assign w_product = $signed(sample_in) * $signed({1'b0, r_amp});
    assign w_unused_bits = ^{w_product[PROD_WIDTH-1], w_product[AMP_WIDTH-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_amp       <= '0;
            r_note_prev <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_amp       <= w_next_amp;
            r_note_prev <= note_on;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_amp   = r_amp;

        if (sample_in_ready) begin
            case (r_state)
                ST_IDLE: begin
                    w_next_amp = '0;
                end
                ST_ATTACK: begin
                    if (w_sum_attack >= {1'b0, c_amp_full}) begin
                        w_next_amp   = c_amp_full;
                        w_next_state = ST_DECAY;
                    end else begin
                        w_next_amp = w_sum_attack[AMP_WIDTH-1:0];
                    end
                end
                ST_DECAY: begin
                    if (w_diff_decay[AMP_WIDTH] ||
                        (w_diff_decay[AMP_WIDTH-1:0] <= sustain_level)) begin
                        w_next_amp   = sustain_level;
                        w_next_state = ST_SUSTAIN;
                    end else begin
                        w_next_amp = w_diff_decay[AMP_WIDTH-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    w_next_amp = sustain_level;
                end
                ST_RELEASE: begin
                    if (w_diff_release[AMP_WIDTH] ||
                        (w_diff_release[AMP_WIDTH-1:0] == '0)) begin
                        w_next_amp   = '0;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_amp = w_diff_release[AMP_WIDTH-1:0];
                    end
                end
                default: begin
                    w_next_amp   = '0;
                    w_next_state = ST_IDLE;
                end
            endcase
        end

        // Key edges win over any threshold transition from the same cycle
        if (w_rise && (r_state == ST_IDLE || r_state == ST_RELEASE)) begin
            w_next_state = ST_ATTACK;
        end else if (w_fall && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                                r_state == ST_SUSTAIN)) begin
            w_next_state = ST_RELEASE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample_out       <= '0;
            r_sample_out_ready <= 1'b0;
        end else begin
            r_sample_out_ready <= sample_in_ready;
            if (sample_in_ready) begin
                r_sample_out <= w_product[SAMPLE_WIDTH+AMP_WIDTH-1:AMP_WIDTH];
            end
        end
    end

    assign sample_out       = r_sample_out;
    assign sample_out_ready = r_sample_out_ready;
    assign amp              = r_amp;
    assign active           = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_note_envelope.sv
//------------------------------------------------------------------------------
// Module   : tb_note_envelope
// Purpose  : Directed self-checking bench for note_envelope.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_note_envelope;

    logic        clk;
    logic        reset;
    logic        note_on;
    logic [15:0] sample_in;
    logic        sample_in_ready;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [15:0] sustain_level;
    logic [15:0] release_step;
    logic [15:0] sample_out;
    logic        sample_out_ready;
    logic [15:0] amp;
    logic        active;

    int total;
    int bad;

    logic [15:0] exp_adsr [12] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF,
                                   16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hBFFF,
                                   16'hAFFF, 16'h9FFF, 16'h8FFF, 16'h8000};

    note_envelope #(
        .SAMPLE_WIDTH (16),
        .AMP_WIDTH    (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .note_on          (note_on),
        .sample_in        (sample_in),
        .sample_in_ready  (sample_in_ready),
        .attack_step      (attack_step),
        .decay_step       (decay_step),
        .sustain_level    (sustain_level),
        .release_step     (release_step),
        .sample_out       (sample_out),
        .sample_out_ready (sample_out_ready),
        .amp              (amp),
        .active           (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic strobe_note(input logic [15:0] s, input logic n);
        @(negedge clk);
        sample_in       = s;
        sample_in_ready = 1'b1;
        note_on         = n;
        @(posedge clk);
        #1;
        sample_in_ready = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] s);
        strobe_note(s, note_on);
    endtask

    task automatic set_note(input logic n);
        @(negedge clk);
        note_on = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset           = 1'b0;
        note_on         = 1'b0;
        sample_in       = '0;
        sample_in_ready = 1'b0;
        attack_step     = 16'h4000;
        decay_step      = 16'h1000;
        sustain_level   = 16'h8000;
        release_step    = 16'h3000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_amp", 32'(amp), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        check("rst_ready", 32'(sample_out_ready), 32'h0);
        check("rst_out", 32'(sample_out), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Idle voice: strobes pass through at zero amplitude
        for (int i = 0; i < 10; i++) begin
            strobe(16'h4000);
            check("idle_ready", 32'(sample_out_ready), 32'h1);
            check("idle_out", 32'(sample_out), 32'h0);
            check("idle_amp", 32'(amp), 32'h0);
            check("idle_active", 32'(active), 32'h0);
        end
        set_note(1'b0);
        check("idle_ready_drop", 32'(sample_out_ready), 32'h0);

        // Attack, decay, sustain
        set_note(1'b1);
        check("attack_active", 32'(active), 32'h1);
        check("attack_amp0", 32'(amp), 32'h0);
        for (int i = 0; i < 12; i++) begin
            strobe(16'h4000);
            check($sformatf("adsr_amp%0d", i), 32'(amp), 32'(exp_adsr[i]));
        end
        strobe(16'h7FFF);
        check("sustain_out", 32'(sample_out), 32'h3FFF);
        check("sustain_amp", 32'(amp), 32'h8000);
        sustain_level = 16'h9000;
        strobe(16'h0000);
        check("sustain_track", 32'(amp), 32'h9000);
        sustain_level = 16'h8000;
        strobe(16'h0000);
        check("sustain_back", 32'(amp), 32'h8000);

        // Release to idle with underflow on the last step
        set_note(1'b0);
        check("release_active", 32'(active), 32'h1);
        strobe(16'h0000);
        check("release_amp1", 32'(amp), 32'h5000);
        strobe(16'h0000);
        check("release_amp2", 32'(amp), 32'h2000);
        check("release_active2", 32'(active), 32'h1);
        strobe(16'h0000);
        check("release_amp3", 32'(amp), 32'h0000);
        check("release_idle", 32'(active), 32'h0);

        // Retrigger during release continues from current amplitude
        decay_step = 16'h8000;
        set_note(1'b1);
        repeat (4) strobe(16'h0000);
        check("re_attack_full", 32'(amp), 32'hFFFF);
        strobe(16'h0000);
        check("re_decay_sustain", 32'(amp), 32'h8000);
        set_note(1'b0);
        strobe(16'h0000);
        check("re_release", 32'(amp), 32'h5000);
        set_note(1'b1);
        strobe(16'h0000);
        check("retrigger_amp", 32'(amp), 32'h9000);

        // Saturation and key release in the same cycle
        attack_step = 16'h3000;
        strobe(16'h0000);
        check("attack_c000", 32'(amp), 32'hC000);
        attack_step = 16'h4000;
        strobe_note(16'h0000, 1'b0);
        check("sat_fall_amp", 32'(amp), 32'hFFFF);
        check("sat_fall_active", 32'(active), 32'h1);
        strobe(16'h0000);
        check("sat_fall_release", 32'(amp), 32'hCFFF);

        // Mid-decay: negative full scale, then asynchronous reset
        decay_step = 16'h1000;
        set_note(1'b1);
        strobe(16'h0000);
        check("decay_entry", 32'(amp), 32'hFFFF);
        strobe(16'h8000);
        check("negfs_out", 32'(sample_out), 32'h8000);
        check("negfs_ready", 32'(sample_out_ready), 32'h1);
        check("decay_amp", 32'(amp), 32'hEFFF);
        reset = 1'b0;
        #1;
        check("arst_ready", 32'(sample_out_ready), 32'h0);
        check("arst_out", 32'(sample_out), 32'h0);
        check("arst_amp", 32'(amp), 32'h0);
        check("arst_active", 32'(active), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("held_note_rise", 32'(active), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
